// File: rtl/posit_defines.sv
// Shared posit-32 (es=2) constants and the datapath hand-off structs.
package posit_defines;

  localparam int unsigned NBITS = 32;
  localparam int unsigned ES    = 2;
  localparam int unsigned FBITS = NBITS - 3 - ES;
  localparam int unsigned ABITS = FBITS + 4;

  localparam int               MAXPOS_SCALE = (NBITS - 2) << ES;
  localparam logic [NBITS-1:0] NAR          = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] MAXPOS       = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] MINPOS       = NBITS'(1);

  typedef struct packed {
    logic              sign;
    logic signed [8:0] scale;
    logic [ES-1:0]     exponent;
    logic [ABITS-1:0]  fraction;
    logic              inf;
    logic              zero;
  } value_sum;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] scale;
    logic [FBITS-1:0]  frac;
    logic              guard;
    logic              sticky;
    logic              inf;
    logic              zero;
  } value_norm;

  typedef struct packed {
    logic             sign;
    logic [NBITS-2:0] body;
    logic             guard;
    logic             sticky;
    logic             sat_hi;
    logic             sat_lo;
    logic             inf;
    logic             zero;
  } value_asm;

endpackage

// File: rtl/posit_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module posit_lzc #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    count_o = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/posit_normalize_round.sv
// Posit adder back end: normalise, assemble regime/exponent, round-to-nearest-even
// and pack; three stages sharing a single stall enable.
module posit_normalize_round
  import posit_defines::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  value_sum         in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_posit,
  output logic             out_inexact
);

  localparam int unsigned       LZW       = $clog2(ABITS + 1);
  localparam logic signed [9:0] SAT_SCALE = 10'(MAXPOS_SCALE);

  logic             en;
  logic [LZW-1:0]   lzc;
  logic [ABITS-1:0] norm_shl;
  logic             unused_bits;

  value_norm        s1_d, s1_q;
  value_asm         s2_d, s2_q;
  logic             s1_valid_q, s2_valid_q, out_valid_q;
  logic [NBITS-1:0] out_posit_d, out_posit_q;
  logic             out_inexact_d, out_inexact_q;

  assign en          = out_ready | ~out_valid_q;
  assign in_ready    = en;
  assign out_valid   = out_valid_q;
  assign out_posit   = out_posit_q;
  assign out_inexact = out_inexact_q;

  posit_lzc #(.WIDTH(ABITS)) u_lzc (
    .data_i  (in_data.fraction),
    .count_o (lzc)
  );

  // lzc >= 1 whenever the carry bit is clear, so the shift lands the hidden bit at ABITS-2
  assign norm_shl    = in_data.fraction << (lzc - LZW'(1));
  assign unused_bits = ^{in_data.exponent, norm_shl[ABITS-1:ABITS-2]};

  // S1: renormalise
  always_comb begin
    logic signed [9:0] scale_ext;
    scale_ext   = {in_data.scale[8], in_data.scale};
    s1_d        = '0;
    s1_d.sign   = in_data.sign;
    s1_d.inf    = in_data.inf;
    s1_d.zero   = in_data.zero | (in_data.fraction == '0);
    if (in_data.fraction[ABITS-1]) begin
      s1_d.scale  = scale_ext + 10'sd1;
      s1_d.frac   = in_data.fraction[ABITS-2:3];
      s1_d.guard  = in_data.fraction[2];
      s1_d.sticky = in_data.fraction[1] | in_data.fraction[0];
    end else begin
      s1_d.scale  = scale_ext + 10'sd1 - 10'(lzc);
      s1_d.frac   = norm_shl[ABITS-3:2];
      s1_d.guard  = norm_shl[1];
      s1_d.sticky = norm_shl[0];
    end
  end

  // S2: a leading {1,0} arithmetic-shifted by k gives k+1 ones then 0; {0,1} shifted
  // logically by ~k (= -k-1) gives -k zeros then 1.
  always_comb begin
    logic signed [9:0]         scale_s;
    logic signed [9:0]         k;
    logic [9:0]                shamt;
    logic                      kneg;
    logic [2*NBITS-1:0]        v0, v;
    logic signed [2*NBITS-1:0] vs;
    scale_s = s1_q.scale;
    k       = scale_s >>> ES;
    kneg    = k[9];
    shamt   = kneg ? ~k : k;
    v0      = {~kneg, kneg, s1_q.scale[ES-1:0], s1_q.frac, s1_q.guard, {NBITS{1'b0}}};
    vs      = $signed(v0) >>> shamt;
    v       = kneg ? (v0 >> shamt) : vs;
    s2_d        = '0;
    s2_d.sign   = s1_q.sign;
    s2_d.body   = v[2*NBITS-1 -: NBITS-1];
    s2_d.guard  = v[NBITS];
    s2_d.sticky = (|v[NBITS-1:0]) | s1_q.sticky;
    s2_d.sat_hi = scale_s > SAT_SCALE;
    s2_d.sat_lo = scale_s < -SAT_SCALE;
    s2_d.inf    = s1_q.inf;
    s2_d.zero   = s1_q.zero;
  end

  // S3: round, saturate, sign
  always_comb begin
    logic             inc;
    logic [NBITS-1:0] mag;
    inc           = s2_q.guard & (s2_q.sticky | s2_q.body[0]);
    mag           = {1'b0, s2_q.body} + NBITS'(inc);
    out_inexact_d = s2_q.guard | s2_q.sticky;
    if (mag[NBITS-1]) mag = MAXPOS;
    if (s2_q.sat_hi) begin
      mag           = MAXPOS;
      out_inexact_d = 1'b1;
    end else if (s2_q.sat_lo) begin
      mag           = MINPOS;
      out_inexact_d = 1'b1;
    end
    out_posit_d = s2_q.sign ? (~mag + NBITS'(1)) : mag;
    if (s2_q.inf) begin
      out_posit_d   = NAR;
      out_inexact_d = 1'b0;
    end else if (s2_q.zero) begin
      out_posit_d   = '0;
      out_inexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_posit_q   <= '0;
      out_inexact_q <= 1'b0;
    end else if (en) begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s1_valid_q    <= in_valid;
      s2_valid_q    <= s1_valid_q;
      out_valid_q   <= s2_valid_q;
      out_posit_q   <= out_posit_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule
